delay_line_ctrl: RTL and testbench

- Sequencing controller that sits directly upstream of the delay RAM (async, single-port, tri-state `data` bus, WE/OE strobes, one of WE/OE active at a time).
- Turns the RAM into a per-channel circular delay line.
- For each incoming audio sample: reads the sample written `delay` samples earlier, then writes the new sample at the write pointer, then advances the pointer.
- Feeds the delayed sample to the downstream panning/mix stage.

---
 rtl/delay_line_ctrl.sv | 114 +++++++++++
 tb/tb_delay_line_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/delay_line_ctrl.sv
// Sequencer that turns an async single-port RAM into a circular delay line:
// read the sample `delay` entries back, then write the new sample and advance.
module delay_line_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    input  logic [ADDR_WIDTH-1:0] delay,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  mem_oe
);

    typedef enum logic [2:0] {IDLE, RD, CAP, TURN, WR, HOLD} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   fill;
    logic [DATA_WIDTH-1:0] s_reg;
    logic [ADDR_WIDTH-1:0] d_reg;
    logic                  drive;
    logic [ADDR_WIDTH-1:0] delay_clamped;

    assign delay_clamped = (delay > LAST_IDX) ? LAST_IDX : delay;
    assign mem_data      = drive ? s_reg : 'z;

    // DEPTH need not be a power of two, so the wrap is explicit.
    function automatic logic [ADDR_WIDTH-1:0] rd_addr(input logic [ADDR_WIDTH-1:0] ptr,
                                                      input logic [ADDR_WIDTH-1:0] d);
        if (ptr < d)
            return ADDR_WIDTH'({1'b0, ptr} + DEPTH_W - {1'b0, d});
        else
            return ptr - d;
    endfunction

    // NOTE: all state and outputs are registers updated with non-blocking
    // assignments; RAM contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            fill       <= '0;
            s_reg      <= '0;
            d_reg      <= '0;
            sample_out <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
            mem_we     <= 1'b0;
            mem_oe     <= 1'b0;
            mem_addr   <= '0;
            drive      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            overrun   <= sample_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        s_reg    <= sample_in;
                        d_reg    <= delay_clamped;
                        mem_addr <= rd_addr(wr_ptr, delay_clamped);
                        mem_oe   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= RD;
                    end
                end
                RD: state <= CAP;
                CAP: begin
                    if (d_reg == '0)
                        sample_out <= s_reg;
                    else if (fill < {1'b0, d_reg})
                        sample_out <= '0;
                    else
                        sample_out <= mem_data;
                    out_valid <= 1'b1;
                    mem_oe    <= 1'b0;
                    mem_addr  <= wr_ptr;
                    state     <= TURN;
                end
                TURN: begin
                    mem_we <= 1'b1;
                    drive  <= 1'b1;
                    state  <= WR;
                end
                WR: begin
                    mem_we <= 1'b0;
                    state  <= HOLD;
                end
                HOLD: begin
                    drive  <= 1'b0;
                    busy   <= 1'b0;
                    wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
                    if (fill != DEPTH_W)
                        fill <= fill + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl on a small DEPTH=8 line: directed tables, corner
// sequences and random traffic against a history-queue reference model.
module tb_delay_line_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] sample_in;
    logic          sample_valid;
    logic [AW-1:0] delay;
    logic [DW-1:0] sample_out;
    logic          out_valid;
    logic          busy;
    logic          overrun;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;
    logic          mem_we;
    logic          mem_oe;

    delay_line_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .delay(delay), .sample_out(sample_out), .out_valid(out_valid), .busy(busy),
        .overrun(overrun), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_we(mem_we), .mem_oe(mem_oe)
    );

    always #5 clk = ~clk;

    // Behavioural async RAM, pre-filled with garbage to expose unprimed reads.
    logic [DW-1:0] ram [16] = '{default: 16'hBEEF};
    assign mem_data = (mem_oe && !mem_we) ? ram[mem_addr] : 'z;
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_data;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int exp_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("we_oe_exclusive", {31'd0, mem_we & mem_oe}, 32'd0);
        if (mem_oe) check("bus_read", {16'd0, mem_data}, {16'd0, ram[mem_addr]});
        if (out_valid) pulses++;
    end

    // Reference model: every sample written since reset, in order.
    logic [DW-1:0] hist[$];
    int            wr_count;

    function automatic int clamp(input logic [AW-1:0] d);
        return (int'(d) > DEPTH - 1) ? DEPTH - 1 : int'(d);
    endfunction

    function automatic logic [DW-1:0] model_out(input logic [DW-1:0] s, input int dc);
        if (dc == 0) return s;
        if (wr_count < dc) return '0;
        return hist[wr_count - dc];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_sample_out", {16'd0, sample_out}, 0);
        check("rst_addr", {28'd0, mem_addr}, 0);
        check("rst_strobes", {30'd0, mem_we, mem_oe}, 0);
        rst = 1'b0;
        hist.delete();
        wr_count = 0;
    endtask

    // One full operation, starting at a negedge in IDLE; dup_at>0 re-strobes
    // sample_valid in that cycle of the operation.
    task automatic run_op(input logic [DW-1:0] s, input logic [AW-1:0] d,
                          input logic [DW-1:0] exp, input int dup_at);
        int dc = clamp(d);
        int ra = ((wr_count - dc) % DEPTH + DEPTH) % DEPTH;
        int wa = wr_count % DEPTH;
        sample_in = s;
        delay = d;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            check("busy", {31'd0, busy}, {31'd0, k <= 5});
            check("mem_oe", {31'd0, mem_oe}, {31'd0, k <= 2});
            check("mem_we", {31'd0, mem_we}, {31'd0, k == 4});
            check("out_valid", {31'd0, out_valid}, {31'd0, k == 3});
            check("overrun", {31'd0, overrun}, {31'd0, dup_at > 0 && k == dup_at + 1});
            if (k <= 2) check("rd_addr", {28'd0, mem_addr}, ra);
            else if (k <= 5) check("wr_addr", {28'd0, mem_addr}, wa);
            if (k == 3) check("sample_out", {16'd0, sample_out}, {16'd0, exp});
            if (k == 4 || k == 5) check("wr_data", {16'd0, mem_data}, {16'd0, s});
            if (k == dup_at) begin
                sample_in = DW'($urandom);
                delay = AW'($urandom);
                sample_valid = 1'b1;
            end else begin
                sample_valid = 1'b0;
            end
            if (k < 6) @(negedge clk);
        end
        check("ram_written", {16'd0, ram[wa]}, {16'd0, s});
        hist.push_back(s);
        wr_count++;
        exp_pulses++;
    endtask

    typedef struct {
        logic [DW-1:0] s;
        logic [AW-1:0] d;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t tv[$];

    initial begin
        sample_in = '0;
        delay = '0;
        sample_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        do_reset();

        // Priming: delay 2 over samples 1..5, plus delay-0 bypass.
        tv.push_back('{16'd1, 4'd2, 16'd0});
        tv.push_back('{16'd2, 4'd2, 16'd0});
        tv.push_back('{16'd3, 4'd2, 16'd1});
        tv.push_back('{16'd4, 4'd2, 16'd2});
        tv.push_back('{16'd5, 4'd2, 16'd3});
        tv.push_back('{16'h1234, 4'd0, 16'h1234});
        foreach (tv[i]) begin
            run_op(tv[i].s, tv[i].d, tv[i].exp, 0);
            repeat (2) @(negedge clk);
        end

        // Full-depth delay with pointer wrap; delay 9 must clamp to 7.
        do_reset();
        tv.delete();
        for (int k = 0; k < 20; k++)
            tv.push_back('{DW'(k), (k < 14) ? 4'd7 : 4'd9, (k >= 7) ? DW'(k - 7) : 16'd0});
        foreach (tv[i]) run_op(tv[i].s, tv[i].d, tv[i].exp, 0);

        // Overrun: second strobe two cycles into an operation is dropped.
        run_op(16'hA5A5, 4'd1, model_out(16'hA5A5, 1), 2);
        run_op(16'h0F0F, 4'd1, 16'hA5A5, 0);

        // Reset in the WR cycle aborts cleanly and empties the line.
        sample_in = 16'h7777;
        delay = 4'd3;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_we", {31'd0, mem_we}, 1);
        exp_pulses++;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_we", {31'd0, mem_we}, 0);
        check("midrst_oe", {31'd0, mem_oe}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_addr", {28'd0, mem_addr}, 0);
        rst = 1'b0;
        hist.delete();
        wr_count = 0;
        run_op(16'h5555, 4'd1, 16'd0, 0);

        // Random traffic against the model.
        for (int n = 0; n < 150; n++) begin
            logic [DW-1:0] s;
            logic [AW-1:0] d;
            int dup;
            s = DW'($urandom);
            d = AW'($urandom);
            dup = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            run_op(s, d, model_out(s, clamp(d)), dup);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        check("out_valid_pulses", pulses, exp_pulses);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
